// File: rtl/mult_div_unit.sv
// Purpose: multicycle signed multiply (radix-2 Booth) and divide (restoring) engine; optional MULTDIV_UNSIGNED_EN adds Is_Unsigned (multu/divu).
// Latency: a start sampled at edge k gives a Done pulse in the cycle after edge k+WIDTH+1 (33 cycles for WIDTH=32).
// Backpressure: none; starts are accepted only in IDLE and ignored while Busy, and a divide by zero pulses Zero_Div instead of running.
module mult_div_unit #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 6
) (
    input  logic             clk,
    input  logic             Reset_In,
    input  logic             Mult_Start,
    input  logic             Div_Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             Is_Unsigned,
`endif
    output logic [WIDTH-1:0] Mult_Hi,
    output logic [WIDTH-1:0] Mult_Lo,
    output logic [WIDTH-1:0] Div_Hi,
    output logic [WIDTH-1:0] Div_Lo,
    output logic             Busy,
    output logic             Done,
    output logic             Zero_Div
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic is_unsigned;
`ifdef MULTDIV_UNSIGNED_EN
    assign is_unsigned = Is_Unsigned;
`else
    assign is_unsigned = 1'b0;
`endif

    logic [CNT_BITS-1:0] cnt;
    logic                start_mult;
    logic                start_div;
    logic                zero_div_req;
    logic                last_iter;
    logic                op_is_div;

    // Booth datapath. The accumulator carries two guard bits above WIDTH so that
    // adding or subtracting the most negative multiplicand (or a zero-extended
    // unsigned one) never wraps before the arithmetic shift.
    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] mlo;
    logic             booth_q;
    logic [WIDTH:0]   mcand;
    logic             mult_fix;
    logic [WIDTH+1:0] mc_ext;
    logic [WIDTH+1:0] booth_sum;
    logic [WIDTH-1:0] mult_hi_fin;

    // Restoring divider on magnitudes; the quotient shifts in where the dividend shifts out.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    logic a_neg;
    logic b_neg;
    logic unused_bits;

    assign a_neg = !is_unsigned && A[WIDTH-1];
    assign b_neg = !is_unsigned && B[WIDTH-1];

    // Start decode and next state; multiply wins when both starts arrive together.
    always_comb begin
        state_nxt    = state;
        start_mult   = 1'b0;
        start_div    = 1'b0;
        zero_div_req = 1'b0;
        last_iter    = (cnt == CNT_BITS'(WIDTH - 1));
        case (state)
            S_IDLE: begin
                if (Mult_Start) begin
                    start_mult = 1'b1;
                    state_nxt  = S_MULT;
                end else if (Div_Start) begin
                    if (B == '0) begin
                        zero_div_req = 1'b1;
                    end else begin
                        start_div = 1'b1;
                        state_nxt = S_DIV;
                    end
                end
            end
            S_MULT, S_DIV: begin
                if (last_iter) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // One Booth step: examine the low multiplier bit and the previous one, add/subtract the multiplicand.
    always_comb begin
        mc_ext = {mcand[WIDTH], mcand};
        case ({mlo[0], booth_q})
            2'b01:   booth_sum = acc + mc_ext;
            2'b10:   booth_sum = acc - mc_ext;
            default: booth_sum = acc;
        endcase
    end

    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dvsr};
    assign div_ge    = (div_shift >= {1'b0, dvsr});

    // An unsigned multiplier with its top bit set was treated as negative by Booth; adding A*2^WIDTH restores it.
    assign mult_hi_fin = acc[WIDTH-1:0] + (mult_fix ? mcand[WIDTH-1:0] : '0);
    // Truncating division: quotient negated on sign mismatch, remainder follows the dividend.
    assign quo_fin     = neg_q ? -quo : quo;
    assign rem_fin     = neg_r ? -rem : rem;

    assign unused_bits = ^{acc[WIDTH+1:WIDTH], div_diff[WIDTH]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (Reset_In) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, iteration counter and per-cycle Booth / restoring steps.
    always_ff @(posedge clk) begin
        if (Reset_In) begin
            cnt       <= '0;
            op_is_div <= 1'b0;
            acc       <= '0;
            mlo       <= '0;
            booth_q   <= 1'b0;
            mcand     <= '0;
            mult_fix  <= 1'b0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (start_mult) begin
            cnt       <= '0;
            op_is_div <= 1'b0;
            acc       <= '0;
            mlo       <= B;
            booth_q   <= 1'b0;
            mcand     <= {a_neg, A};
            mult_fix  <= is_unsigned && B[WIDTH-1];
        end else if (start_div) begin
            cnt       <= '0;
            op_is_div <= 1'b1;
            rem       <= '0;
            quo       <= a_neg ? -A : A;
            dvsr      <= b_neg ? -B : B;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
        end else if (state == S_MULT) begin
            cnt     <= cnt + CNT_BITS'(1);
            acc     <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
            mlo     <= {booth_sum[0], mlo[WIDTH-1:1]};
            booth_q <= mlo[0];
        end else if (state == S_DIV) begin
            cnt <= cnt + CNT_BITS'(1);
            rem <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], div_ge};
        end
    end

    // Result registers and status flags; each result pair only changes when its own operation finishes.
    always_ff @(posedge clk) begin
        if (Reset_In) begin
            Mult_Hi  <= '0;
            Mult_Lo  <= '0;
            Div_Hi   <= '0;
            Div_Lo   <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Zero_Div <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Zero_Div <= zero_div_req;
            if (start_mult || start_div) begin
                Busy <= 1'b1;
            end
            if (state == S_FINISH) begin
                Busy <= 1'b0;
                Done <= 1'b1;
                if (op_is_div) begin
                    Div_Hi <= rem_fin;
                    Div_Lo <= quo_fin;
                end else begin
                    Mult_Hi <= mult_hi_fin;
                    Mult_Lo <= mlo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: self-checking bench for mult_div_unit using a scoreboard of expected results.
// Latency: each operation is expected to complete 33 cycles after its start edge.
// Backpressure: starts are only issued when the unit is idle, except where ignoring them is the point.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        Reset_In;
    logic        Mult_Start;
    logic        Div_Start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Mult_Hi;
    logic [31:0] Mult_Lo;
    logic [31:0] Div_Hi;
    logic [31:0] Div_Lo;
    logic        Busy;
    logic        Done;
    logic        Zero_Div;
`ifdef MULTDIV_UNSIGNED_EN
    logic        Is_Unsigned = 1'b0;
`endif

    mult_div_unit #(.WIDTH(32), .CNT_BITS(6)) dut (
        .clk        (clk),
        .Reset_In   (Reset_In),
        .Mult_Start (Mult_Start),
        .Div_Start  (Div_Start),
        .A          (A),
        .B          (B),
`ifdef MULTDIV_UNSIGNED_EN
        .Is_Unsigned(Is_Unsigned),
`endif
        .Mult_Hi    (Mult_Hi),
        .Mult_Lo    (Mult_Lo),
        .Div_Hi     (Div_Hi),
        .Div_Lo     (Div_Lo),
        .Busy       (Busy),
        .Done       (Done),
        .Zero_Div   (Zero_Div)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_div;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mult_hold_hi = '0;
    logic [31:0] mult_hold_lo = '0;
    logic [31:0] div_hold_hi  = '0;
    logic [31:0] div_hold_lo  = '0;

    // Called at a negedge: hold the start pulse(s) across one rising edge, then drop them.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        Mult_Start = m;
        Div_Start  = d;
        A          = a;
        B          = b;
        @(posedge clk);
        @(negedge clk);
        Mult_Start = 1'b0;
        Div_Start  = 1'b0;
    endtask

    task automatic push_exp(input bit is_div, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.is_div = is_div;
        e.hi     = hi;
        e.lo     = lo;
        exp_q.push_back(e);
    endtask

    // Counts cycles until Done (0 = never seen within budget); Busy must be high until then and low with Done.
    task automatic wait_done(output int lat, output bit busy_ok);
        bit found;
        found   = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 100 && !found; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (Done === 1'b1) begin
                found = 1'b1;
                lat   = i;
                if (Busy !== 1'b0) busy_ok = 1'b0;
            end else if (Busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        Reset_In   = 1'b1;
        Mult_Start = 1'b0;
        Div_Start  = 1'b0;
        A          = '0;
        B          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        Reset_In = 1'b0;
        checks++;
        if ({Mult_Hi, Mult_Lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mult got %h_%h want 0", Mult_Hi, Mult_Lo);
        end
        checks++;
        if ({Div_Hi, Div_Lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_div got %h_%h want 0", Div_Hi, Div_Lo);
        end
        checks++;
        if ({Busy, Done, Zero_Div} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got busy/done/zd=%b want 000", {Busy, Done, Zero_Div});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({Busy, Done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got busy/done=%b want 00", {Busy, Done});
        end
    endtask

    task automatic test_mult_basic();
        logic [31:0] ta[2];
        logic [31:0] tb[2];
        logic [31:0] th[2];
        logic [31:0] tl[2];
        int          lat;
        bit          bok;
        exp_t        e;
        ta[0] = 32'd7;        tb[0] = 32'hFFFFFFFD; th[0] = 32'hFFFFFFFF; tl[0] = 32'hFFFFFFEB;
        ta[1] = 32'h80000000; tb[1] = 32'h80000000; th[1] = 32'h40000000; tl[1] = 32'h00000000;
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, th[i], tl[i]);
            issue(1'b1, 1'b0, ta[i], tb[i]);
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("FAIL mult%0d_busy_start got %b want 1", i, Busy);
            end
            wait_done(lat, bok);
            checks++;
            if (lat != 33) begin
                errors++;
                $display("FAIL mult%0d_latency got %0d want 33", i, lat);
            end
            checks++;
            if (!bok) begin
                errors++;
                $display("FAIL mult%0d_busy got busy not high through op want high until done", i);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mult%0d_scoreboard got empty queue want entry", i);
            end else begin
                e = exp_q.pop_front();
                if ({Mult_Hi, Mult_Lo} !== {e.hi, e.lo}) begin
                    errors++;
                    $display("FAIL mult%0d_result got %h_%h want %h_%h", i, Mult_Hi, Mult_Lo, e.hi, e.lo);
                end
                mult_hold_hi = e.hi;
                mult_hold_lo = e.lo;
            end
            checks++;
            if ({Div_Hi, Div_Lo} !== {div_hold_hi, div_hold_lo}) begin
                errors++;
                $display("FAIL mult%0d_div_kept got %h_%h want %h_%h", i, Div_Hi, Div_Lo, div_hold_hi, div_hold_lo);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (Done !== 1'b0) begin
                errors++;
                $display("FAIL mult%0d_done_width got %b want 0", i, Done);
            end
        end
    endtask

    task automatic test_div_basic();
        logic [31:0] ta[4];
        logic [31:0] tb[4];
        logic [31:0] th[4];
        logic [31:0] tl[4];
        int          lat;
        bit          bok;
        exp_t        e;
        ta[0] = 32'hFFFFFFF9; tb[0] = 32'd2;        th[0] = 32'hFFFFFFFF; tl[0] = 32'hFFFFFFFD;
        ta[1] = 32'h80000000; tb[1] = 32'hFFFFFFFF; th[1] = 32'h00000000; tl[1] = 32'h80000000;
        ta[2] = 32'd7;        tb[2] = 32'hFFFFFFFE; th[2] = 32'd1;        tl[2] = 32'hFFFFFFFD;
        ta[3] = 32'd100;      tb[3] = 32'd7;        th[3] = 32'd2;        tl[3] = 32'd14;
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b1, th[i], tl[i]);
            issue(1'b0, 1'b1, ta[i], tb[i]);
            wait_done(lat, bok);
            checks++;
            if (lat != 33 || !bok) begin
                errors++;
                $display("FAIL div%0d_timing got lat=%0d busy_ok=%0d want 33/1", i, lat, bok);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL div%0d_scoreboard got empty queue want entry", i);
            end else begin
                e = exp_q.pop_front();
                if ({Div_Hi, Div_Lo} !== {e.hi, e.lo}) begin
                    errors++;
                    $display("FAIL div%0d_result got rem/quo %h_%h want %h_%h", i, Div_Hi, Div_Lo, e.hi, e.lo);
                end
                div_hold_hi = e.hi;
                div_hold_lo = e.lo;
            end
            checks++;
            if ({Mult_Hi, Mult_Lo} !== {mult_hold_hi, mult_hold_lo}) begin
                errors++;
                $display("FAIL div%0d_mult_kept got %h_%h want %h_%h", i, Mult_Hi, Mult_Lo, mult_hold_hi, mult_hold_lo);
            end
        end
    endtask

    task automatic test_zero_div();
        bit done_seen;
        bit busy_seen;
        issue(1'b0, 1'b1, 32'd100, 32'd0);
        checks++;
        if ({Zero_Div, Busy} !== 2'b10) begin
            errors++;
            $display("FAIL zero_div_pulse got zd/busy=%b want 10", {Zero_Div, Busy});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Zero_Div !== 1'b0) begin
            errors++;
            $display("FAIL zero_div_width got %b want 0", Zero_Div);
        end
        done_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (Done !== 1'b0) done_seen = 1'b1;
            if (Busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++;
        if (done_seen || busy_seen) begin
            errors++;
            $display("FAIL zero_div_quiet got done=%0d busy=%0d want 0/0", done_seen, busy_seen);
        end
        checks++;
        if ({Div_Hi, Div_Lo} !== {div_hold_hi, div_hold_lo}) begin
            errors++;
            $display("FAIL zero_div_kept got %h_%h want %h_%h", Div_Hi, Div_Lo, div_hold_hi, div_hold_lo);
        end
    endtask

    task automatic test_reset_abort();
        int   lat;
        bit   bok;
        bit   done_seen;
        exp_t e;
        push_exp(1'b0, 32'd0, 32'd99);
        issue(1'b1, 1'b0, 32'd9, 32'd11);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        Reset_In = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Reset_In = 1'b0;
        exp_q.delete();
        mult_hold_hi = '0;
        mult_hold_lo = '0;
        div_hold_hi  = '0;
        div_hold_lo  = '0;
        checks++;
        if ({Mult_Hi, Mult_Lo, Div_Hi, Div_Lo, Busy, Done, Zero_Div} !== 131'd0) begin
            errors++;
            $display("FAIL abort_outputs got %h_%h %h_%h b/d/z=%b want all 0",
                     Mult_Hi, Mult_Lo, Div_Hi, Div_Lo, {Busy, Done, Zero_Div});
        end
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (Done !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen) begin
            errors++;
            $display("FAIL abort_no_done got done after reset want none");
        end
        push_exp(1'b0, 32'd0, 32'd15);
        issue(1'b1, 1'b0, 32'd3, 32'd5);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        issue(1'b0, 1'b1, 32'd10, 32'd2);
        wait_done(lat, bok);
        checks++;
        if (lat != 27 || !bok) begin
            errors++;
            $display("FAIL abort_restart_timing got lat=%0d busy_ok=%0d want 27/1", lat, bok);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL abort_scoreboard got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if ({Mult_Hi, Mult_Lo} !== {e.hi, e.lo}) begin
                errors++;
                $display("FAIL abort_restart_result got %h_%h want %h_%h", Mult_Hi, Mult_Lo, e.hi, e.lo);
            end
            mult_hold_hi = e.hi;
            mult_hold_lo = e.lo;
        end
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (Done !== 1'b0) done_seen = 1'b1;
        end
        checks++;
        if (done_seen || {Div_Hi, Div_Lo} !== 64'd0) begin
            errors++;
            $display("FAIL busy_div_ignored got done=%0d div=%h_%h want 0 and 0_0", done_seen, Div_Hi, Div_Lo);
        end
    endtask

    task automatic test_both_starts();
        int   lat;
        bit   bok;
        int   extra_done;
        exp_t e;
        push_exp(1'b0, 32'd0, 32'd18);
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        wait_done(lat, bok);
        checks++;
        if (lat != 33 || !bok) begin
            errors++;
            $display("FAIL both_timing got lat=%0d busy_ok=%0d want 33/1", lat, bok);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL both_scoreboard got empty queue want entry");
        end else begin
            e = exp_q.pop_front();
            if ({Mult_Hi, Mult_Lo} !== {e.hi, e.lo}) begin
                errors++;
                $display("FAIL both_mult got %h_%h want %h_%h", Mult_Hi, Mult_Lo, e.hi, e.lo);
            end
            mult_hold_hi = e.hi;
            mult_hold_lo = e.lo;
        end
        extra_done = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (Done === 1'b1) extra_done++;
        end
        checks++;
        if (extra_done != 0 || Div_Lo !== 32'd0) begin
            errors++;
            $display("FAIL both_single_done got extra_done=%0d div_lo=%h want 0 and 0", extra_done, Div_Lo);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        bit          bok;
        exp_t        e;
        bit          kind;
        logic [31:0] a;
        logic [31:0] b;
        longint      p;
        int          sa;
        int          sb;
        for (int n = 0; n < 10; n++) begin
            kind = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            if (n % 3 == 0) b = {{24{b[7]}}, b[7:0]};
            if (kind) begin
                if (b == 32'd0) b = 32'd5;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
                sa = int'(a);
                sb = int'(b);
                push_exp(1'b1, 32'(sa % sb), 32'(sa / sb));
            end else begin
                p = longint'($signed(a)) * longint'($signed(b));
                push_exp(1'b0, p[63:32], p[31:0]);
            end
            issue(1'b0 == kind, kind, a, b);
            wait_done(lat, bok);
            checks++;
            if (lat != 33 || !bok) begin
                errors++;
                $display("FAIL b2b%0d_timing got lat=%0d busy_ok=%0d want 33/1", n, lat, bok);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL b2b%0d_scoreboard got empty queue want entry", n);
            end else begin
                e = exp_q.pop_front();
                if (e.is_div) begin
                    if ({Div_Hi, Div_Lo, Mult_Hi, Mult_Lo} !== {e.hi, e.lo, mult_hold_hi, mult_hold_lo}) begin
                        errors++;
                        $display("FAIL b2b%0d_div a=%h b=%h got %h_%h mult %h_%h want %h_%h mult %h_%h",
                                 n, a, b, Div_Hi, Div_Lo, Mult_Hi, Mult_Lo, e.hi, e.lo, mult_hold_hi, mult_hold_lo);
                    end
                    div_hold_hi = e.hi;
                    div_hold_lo = e.lo;
                end else begin
                    if ({Mult_Hi, Mult_Lo, Div_Hi, Div_Lo} !== {e.hi, e.lo, div_hold_hi, div_hold_lo}) begin
                        errors++;
                        $display("FAIL b2b%0d_mult a=%h b=%h got %h_%h div %h_%h want %h_%h div %h_%h",
                                 n, a, b, Mult_Hi, Mult_Lo, Div_Hi, Div_Lo, e.hi, e.lo, div_hold_hi, div_hold_lo);
                    end
                    mult_hold_hi = e.hi;
                    mult_hold_lo = e.lo;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_zero_div();
        test_reset_abort();
        test_both_starts();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
